// File: rtl/fifo_rd_ctrl.sv
//------------------------------------------------------------------------------
// fifo_rd_ctrl
//
// Read-domain controller of an asynchronous FIFO. Holds the binary and Gray
// read pointers, drives the dual-port memory read address and derives the
// empty / almost-empty / fill-level / underflow status from the write pointer
// after it has been synchronized into rclk.
//
// Status is computed against the synchronized (delayed) write pointer. The
// FIFO can therefore look emptier than it really is, but never fuller.
//
// Parameters:
//   ADDRSIZE       memory address width, depth = 2**ADDRSIZE
//   AEMPTY_THRESH  raempty is set when the fill level is <= this value
//
// Ports:
//   rclk        read clock, all state on the rising edge
//   rrst        synchronous active-high reset
//   rinc        read request, honoured only while rempty = 0
//   rq2_wptr    Gray write pointer, already synchronized into rclk
//   raddr       memory read address (low bits of the binary read pointer)
//   rptr        registered Gray read pointer, carried to the write domain
//   rempty      FIFO empty (registered)
//   raempty     FIFO almost empty (registered)
//   rlevel      fill level 0 .. 2**ADDRSIZE (registered)
//   runderflow  sticky flag: a read was attempted while empty
//------------------------------------------------------------------------------
module fifo_rd_ctrl #(
    parameter int ADDRSIZE      = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                runderflow
);

    localparam logic [ADDRSIZE:0] AEMPTY_LVL = (ADDRSIZE+1)'(AEMPTY_THRESH);

    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] rbinnext;
    logic [ADDRSIZE:0] rgraynext;
    logic [ADDRSIZE:0] wbin_s;
    logic [ADDRSIZE:0] rlevel_next;
    logic              rd_en;

    // A request while empty is dropped so the pointer can never pass the
    // write pointer; it only raises runderflow.
    assign rd_en     = rinc & ~rempty;
    assign rbinnext  = rbin + {{ADDRSIZE{1'b0}}, rd_en};
    assign rgraynext = (rbinnext >> 1) ^ rbinnext;

    // Zero-latency read: the address follows the current pointer directly, so
    // the memory already presents the word that this rinc consumes.
    assign raddr = rbin[ADDRSIZE-1:0];

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wbin_s = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            wbin_s[i] = ^(rq2_wptr >> i);
        end
    end

    // Modulo subtraction with one extra wrap bit yields 0 .. 2**ADDRSIZE
    // because the write side never overflows.
    assign rlevel_next = wbin_s - rbinnext;

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values; reset is synchronous and takes priority over rinc.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin       <= '0;
            rptr       <= '0;
            rempty     <= 1'b1;
            raempty    <= 1'b1;
            rlevel     <= '0;
            runderflow <= 1'b0;
        end else begin
            rbin       <= rbinnext;
            rptr       <= rgraynext;
            // Compared on the next pointer so rempty rises on the very edge
            // that consumes the last entry, blocking a back-to-back read.
            rempty     <= (rgraynext == rq2_wptr);
            rlevel     <= rlevel_next;
            raempty    <= (rlevel_next <= AEMPTY_LVL);
            runderflow <= runderflow | (rinc & rempty);
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
//------------------------------------------------------------------------------
// tb_fifo_rd_ctrl
//
// Self-checking bench for fifo_rd_ctrl (ADDRSIZE=4, AEMPTY_THRESH=2). The
// reference model tracks plain integer counts of entries written (as made
// visible through rq2_wptr) and entries read, and derives every expected
// output from those counts.
//------------------------------------------------------------------------------
module tb_fifo_rd_ctrl;

    localparam int AW = 4;
    localparam int AE = 2;

    logic          rclk;
    logic          rrst;
    logic          rinc;
    logic [AW:0]   rq2_wptr;
    logic [AW-1:0] raddr;
    logic [AW:0]   rptr;
    logic          rempty;
    logic          raempty;
    logic [AW:0]   rlevel;
    logic          runderflow;

    int checks = 0;
    int errors = 0;

    // reference model state
    int   m_w     = 0;
    int   m_rd    = 0;
    int   m_level = 0;
    logic m_empty = 1'b1;
    logic m_aempty = 1'b1;
    logic m_uf    = 1'b0;

    fifo_rd_ctrl #(.ADDRSIZE(AW), .AEMPTY_THRESH(AE)) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .rinc       (rinc),
        .rq2_wptr   (rq2_wptr),
        .raddr      (raddr),
        .rptr       (rptr),
        .rempty     (rempty),
        .raempty    (raempty),
        .rlevel     (rlevel),
        .runderflow (runderflow)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    function automatic logic [AW:0] gray(input int v);
        logic [AW:0] b;
        b = (AW+1)'(v % (1 << (AW+1)));
        return (b >> 1) ^ b;
    endfunction

    // Drive one cycle of stimulus on the falling edge, advance the model on
    // the rising edge, and return 1 time unit later for sampling.
    task automatic cycle(input logic rst, input logic inc, input int w);
        @(negedge rclk);
        rrst     = rst;
        rinc     = inc;
        rq2_wptr = gray(w);
        m_w      = w;
        @(posedge rclk);
        if (rst) begin
            m_rd  = 0;
            m_uf  = 1'b0;
            m_level = 0;
            m_empty = 1'b1;
            m_aempty = 1'b1;
        end else begin
            if (inc && m_empty) m_uf = 1'b1;
            if (inc && !m_empty) m_rd++;
            m_level  = m_w - m_rd;
            m_empty  = (m_level == 0);
            m_aempty = (m_level <= AE);
        end
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 1'b1, 2);   // rq2_wptr = 00011
            checks++; if (rptr !== 5'b00000) begin errors++; $display("FAIL rst_rptr got %b exp 00000", rptr); end
            checks++; if (raddr !== 4'd0) begin errors++; $display("FAIL rst_raddr got %0d exp 0", raddr); end
            checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL rst_rempty got %b exp 1", rempty); end
            checks++; if (raempty !== 1'b1) begin errors++; $display("FAIL rst_raempty got %b exp 1", raempty); end
            checks++; if (rlevel !== 5'd0) begin errors++; $display("FAIL rst_rlevel got %0d exp 0", rlevel); end
            checks++; if (runderflow !== 1'b0) begin errors++; $display("FAIL rst_runderflow got %b exp 0", runderflow); end
        end
        cycle(1'b0, 1'b0, 2);
        checks++; if (rempty !== 1'b0) begin errors++; $display("FAIL rst_release_rempty got %b exp 0", rempty); end
        checks++; if (rlevel !== 5'd2) begin errors++; $display("FAIL rst_release_rlevel got %0d exp 2", rlevel); end
        checks++; if (raempty !== 1'b1) begin errors++; $display("FAIL rst_release_raempty got %b exp 1", raempty); end
    endtask

    task automatic test_fill();
        int          exp_lvl [3] = '{1, 2, 3};
        logic        exp_ae  [3] = '{1'b1, 1'b1, 1'b0};
        cycle(1'b1, 1'b0, 0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, k + 1);
            checks++; if (rempty !== 1'b0) begin errors++; $display("FAIL fill_rempty step %0d got %b exp 0", k, rempty); end
            checks++; if (rlevel !== (AW+1)'(exp_lvl[k])) begin errors++; $display("FAIL fill_rlevel step %0d got %0d exp %0d", k, rlevel, exp_lvl[k]); end
            checks++; if (raempty !== exp_ae[k]) begin errors++; $display("FAIL fill_raempty step %0d got %b exp %b", k, raempty, exp_ae[k]); end
        end
    endtask

    task automatic test_drain();
        logic [AW-1:0] exp_addr [4] = '{4'd1, 4'd2, 4'd3, 4'd3};
        logic [AW:0]   exp_ptr  [4] = '{5'b00001, 5'b00011, 5'b00010, 5'b00010};
        logic          exp_emp  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic          exp_uf   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int            exp_lvl  [4] = '{2, 1, 0, 0};
        checks++; if (raddr !== 4'd0) begin errors++; $display("FAIL drain_raddr_start got %0d exp 0", raddr); end
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b1, 3);   // rq2_wptr = 00010
            checks++; if (raddr !== exp_addr[k]) begin errors++; $display("FAIL drain_raddr step %0d got %0d exp %0d", k, raddr, exp_addr[k]); end
            checks++; if (rptr !== exp_ptr[k]) begin errors++; $display("FAIL drain_rptr step %0d got %b exp %b", k, rptr, exp_ptr[k]); end
            checks++; if (rempty !== exp_emp[k]) begin errors++; $display("FAIL drain_rempty step %0d got %b exp %b", k, rempty, exp_emp[k]); end
            checks++; if (runderflow !== exp_uf[k]) begin errors++; $display("FAIL drain_runderflow step %0d got %b exp %b", k, runderflow, exp_uf[k]); end
            checks++; if (rlevel !== (AW+1)'(exp_lvl[k])) begin errors++; $display("FAIL drain_rlevel step %0d got %0d exp %0d", k, rlevel, exp_lvl[k]); end
        end
    endtask

    task automatic test_sticky_underflow();
        cycle(1'b0, 1'b0, 4);
        checks++; if (rempty !== 1'b0) begin errors++; $display("FAIL sticky_rempty got %b exp 0", rempty); end
        for (int k = 0; k < 4; k++) begin
            // alternate write-visible and read cycles, reading only when data exists
            cycle(1'b0, !m_empty, (k % 2 == 0) ? m_w : m_w + 1);
            checks++; if (runderflow !== 1'b1) begin errors++; $display("FAIL sticky_runderflow step %0d got %b exp 1", k, runderflow); end
            checks++; if (rlevel !== (AW+1)'(m_level)) begin errors++; $display("FAIL sticky_rlevel step %0d got %0d exp %0d", k, rlevel, m_level); end
        end
        cycle(1'b1, 1'b0, 0);
        checks++; if (runderflow !== 1'b0) begin errors++; $display("FAIL sticky_cleared got %b exp 0", runderflow); end
    endtask

    task automatic test_wrap_random();
        int          budget = 600;
        int          max_level = 0;
        bit          seen_ptr_wrap = 0;
        bit          seen_addr_wrap = 0;
        logic [AW:0]   prev_ptr;
        logic [AW-1:0] prev_addr;
        logic          do_r;
        int            w_next;
        while ((m_w < 40 || m_rd < 40) && budget > 0) begin
            budget--;
            // first 16 cycles fill to full, afterwards random interleave
            if (m_w < 16) begin
                w_next = m_w + 1;
                do_r   = 1'b0;
            end else begin
                w_next = ((m_w - m_rd) < 16 && $urandom_range(0, 2) != 0) ? m_w + 1 : m_w;
                do_r   = !m_empty && ($urandom_range(0, 2) != 0);
            end
            prev_ptr  = rptr;
            prev_addr = raddr;
            cycle(1'b0, do_r, w_next);
            if (m_level > max_level) max_level = m_level;
            if (prev_ptr == 5'b10000 && rptr == 5'b00000) seen_ptr_wrap = 1;
            if (prev_addr == 4'd15 && raddr == 4'd0) seen_addr_wrap = 1;
            checks++; if (raddr !== (AW)'(m_rd % 16)) begin errors++; $display("FAIL wrap_raddr got %0d exp %0d", raddr, m_rd % 16); end
            checks++; if (rptr !== gray(m_rd)) begin errors++; $display("FAIL wrap_rptr got %b exp %b", rptr, gray(m_rd)); end
            checks++; if (rempty !== m_empty) begin errors++; $display("FAIL wrap_rempty got %b exp %b", rempty, m_empty); end
            checks++; if (raempty !== m_aempty) begin errors++; $display("FAIL wrap_raempty got %b exp %b", raempty, m_aempty); end
            checks++; if (rlevel !== (AW+1)'(m_level)) begin errors++; $display("FAIL wrap_rlevel got %0d exp %0d", rlevel, m_level); end
            checks++; if (runderflow !== 1'b0) begin errors++; $display("FAIL wrap_runderflow got %b exp 0", runderflow); end
        end
        checks++; if (budget == 0) begin errors++; $display("FAIL wrap_budget got reads %0d writes %0d exp 40 each", m_rd, m_w); end
        checks++; if (!seen_ptr_wrap) begin errors++; $display("FAIL wrap_rptr_10000_to_0 got 0 exp 1"); end
        checks++; if (!seen_addr_wrap) begin errors++; $display("FAIL wrap_raddr_15_to_0 got 0 exp 1"); end
        checks++; if (max_level != 16) begin errors++; $display("FAIL wrap_peak_level got %0d exp 16", max_level); end
    endtask

    task automatic test_simultaneous();
        logic [AW-1:0] addr_before;
        cycle(1'b1, 1'b0, 0);
        cycle(1'b0, 1'b0, 1);
        checks++; if (rlevel !== 5'd1) begin errors++; $display("FAIL simul_setup_rlevel got %0d exp 1", rlevel); end
        addr_before = raddr;
        cycle(1'b0, 1'b1, 2);
        checks++; if (rempty !== 1'b0) begin errors++; $display("FAIL simul_rempty got %b exp 0", rempty); end
        checks++; if (rlevel !== 5'd1) begin errors++; $display("FAIL simul_rlevel got %0d exp 1", rlevel); end
        checks++; if (raddr !== addr_before + 4'd1) begin errors++; $display("FAIL simul_raddr got %0d exp %0d", raddr, addr_before + 4'd1); end
        checks++; if (rptr !== gray(m_rd)) begin errors++; $display("FAIL simul_rptr got %b exp %b", rptr, gray(m_rd)); end
    endtask

    initial begin
        rrst     = 1'b1;
        rinc     = 1'b0;
        rq2_wptr = '0;
        test_reset();
        test_fill();
        test_drain();
        test_sticky_underflow();
        test_wrap_random();
        test_simultaneous();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-domain controller for the asynchronous FIFO. It holds the binary and Gray read pointers, produces the read address for the dual-port memory, and generates empty, almost-empty, fill-level and underflow status. Its inputs come from the write pointer after it has been synchronized into the read clock domain. Its Gray read pointer output is the value the read-to-write synchronizer carries back to the write side.

## Interface

Parameters:
- ADDRSIZE, 4: memory address width; FIFO depth is 2^ADDRSIZE.
- AEMPTY_THRESH, 2: raempty asserts when the fill level is at or below this value. Legal range 0..2^ADDRSIZE-1.

Ports:
- rclk, input, 1: read clock. All logic is on its rising edge.
- rrst, input, 1: synchronous, active-high reset.
- rinc, input, 1: read request. A request is honoured only while rempty=0.
- rq2_wptr, input, ADDRSIZE+1: Gray-coded write pointer, already synchronized into rclk. It changes by at most one Gray step per rclk.
- raddr, output, ADDRSIZE: memory read address, equal to rbin[ADDRSIZE-1:0].
- rptr, output, ADDRSIZE+1: registered Gray read pointer, sent to the write domain.
- rempty, output, 1: FIFO empty, registered.
- raempty, output, 1: almost empty, registered.
- rlevel, output, ADDRSIZE+1: registered fill level, range 0..2^ADDRSIZE.
- runderflow, output, 1: sticky flag, set by a read attempted while empty.

## Operation

- State registers: rbin (ADDRSIZE+1 bits), rptr, rempty, raempty, rlevel, runderflow.
- Next-state arithmetic:
  - rbinnext = rbin + (rinc & ~rempty), modulo 2^(ADDRSIZE+1).
  - rgraynext = (rbinnext >> 1) ^ rbinnext.
- Write-pointer decode: wbin_s = Gray-to-binary(rq2_wptr), where wbin_s[i] is the XOR of rq2_wptr[ADDRSIZE:i].
- Level: rlevel_next = (wbin_s - rbinnext) mod 2^(ADDRSIZE+1). It is never negative and never exceeds 2^ADDRSIZE, because the write side guarantees no overflow.
- Register updates on every rclk edge when rrst=0:
  - rbin <= rbinnext
  - rptr <= rgraynext
  - rempty <= (rgraynext == rq2_wptr)
  - rlevel <= rlevel_next
  - raempty <= (rlevel_next <= AEMPTY_THRESH)
  - runderflow <= runderflow | (rinc & rempty)
- Read while empty: the pointer does not move, memory state is unaffected, and runderflow sets. runderflow clears only on rrst.
- Pessimistic status: rempty, rlevel and raempty are computed from the synchronized, delayed write pointer. The FIFO may therefore appear emptier than it is, but never fuller.
- Reset (rrst=1 at an rclk edge): rbin=0, rptr=0, rempty=1, raempty=1, rlevel=0, runderflow=0. raddr=0 follows from rbin. Reset overrides rinc and rq2_wptr in the same cycle, and a reset in mid-operation discards the pointer state with no partial update.

## Timing

- raddr is combinational from rbin. Read data is valid at the memory output during the cycle in which rinc is sampled, so a read has zero cycles of added latency.
- A sampled rinc advances raddr and rptr on the same edge.
- rempty asserts on the same edge that consumes the last entry, because it is computed from rgraynext. A back-to-back rinc on the next cycle is therefore blocked.
- rempty deasserts one rclk after rq2_wptr first differs from rptr.
- rlevel and raempty lag changes in rinc and rq2_wptr by exactly one rclk.
- Simultaneous read and write-pointer advance in one cycle: rlevel is unchanged. If the read consumes the last visible entry while rq2_wptr advances in the same cycle, rempty stays 0.
- Wrap-around: rbin goes from 2^(ADDRSIZE+1)-1 to 0. With ADDRSIZE=4, rptr goes 10000 -> 00000 and raddr goes 15 -> 0, with no glitch on rempty.
- runderflow rises one rclk after the offending rinc.

## Test plan

With ADDRSIZE=4 and AEMPTY_THRESH=2:

1. Reset priority: hold rrst=1 for 2 cycles with rinc=1 and rq2_wptr=00011 -> after each edge, rptr=0, raddr=0, rempty=1, raempty=1, rlevel=0, runderflow=0. Release rrst -> next edge gives rempty=0, rlevel=2.
2. Fill visibility: from reset, step rq2_wptr through 00001, 00011, 00010 on consecutive cycles with rinc=0 -> rempty falls one cycle after the first step; rlevel goes 1, 2, 3; raempty falls on the edge where rlevel becomes 3.
3. Drain: with rq2_wptr=00010, hold rinc=1 for 4 cycles -> raddr 0, 1, 2 then held at 3. rptr goes 00001, 00011, 00010. rempty=1 on the third edge, so the fourth rinc is ignored and runderflow=1 one cycle later. rlevel=0.
4. Sticky underflow: after scenario 3, advance rq2_wptr and read normally -> runderflow stays 1 until rrst.
5. Wrap and full: advance the write pointer 40 entries and the reader 40 entries interleaved, with the write side at most 16 ahead -> rptr 10000 -> 00000 transition observed, raddr 15 -> 0, rlevel peaks at 16 when the write pointer is 16 ahead, and no spurious rempty.
6. Simultaneous events: rlevel=1 and rinc=1 on the same cycle that rq2_wptr advances one step -> rempty stays 0, rlevel stays 1, raddr increments by 1.
